// File: rtl/seq_detector_fsm.sv
// seq_detector_fsm: parametrised Mealy serial-pattern detector with run-time pattern and saturating match counter
// Optional build macro SEQDET_REG_OUT_EN: register y so it asserts one cycle after the hit edge.
module seq_detector_fsm #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             x,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);
  localparam int FW = $clog2(PAT_W);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;
  state_t           r_state, w_state_nx;
  logic [PAT_W-1:0] r_pat, w_pat_nx, w_shift;
  logic [PAT_W-2:0] r_hist, w_hist_nx;
  logic [FW-1:0]    r_fill, w_fill_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             w_acc, w_hit;
  assign w_shift   = {r_hist, x};
  assign w_acc     = in_valid && !pat_load && r_state != S_IDLE;
  assign w_hit     = w_acc && r_state == S_RUN && w_shift == r_pat;
  assign armed     = r_state != S_IDLE;
  assign match_cnt = r_cnt;
  // next-state: pattern load wins, then accepted bits fill the history or test for a hit
  always_comb begin
    w_state_nx = r_state;
    w_pat_nx   = r_pat;
    w_hist_nx  = r_hist;
    w_fill_nx  = r_fill;
    w_cnt_nx   = cnt_clr ? '0 : (w_hit && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    if (pat_load) begin
      w_pat_nx   = pat_in;
      w_hist_nx  = '0;
      w_fill_nx  = '0;
      w_state_nx = S_FILL;
    end else if (w_acc) begin
      w_hist_nx = w_shift[PAT_W-2:0];
      if (r_state == S_FILL) begin
        w_fill_nx = r_fill + 1'b1;
        if (r_fill == FW'(PAT_W-2)) w_state_nx = S_RUN;
      end else if (w_hit && !overlap) begin
        w_hist_nx  = '0;
        w_fill_nx  = '0;
        w_state_nx = S_FILL;
      end
    end
  end
  // state, pattern, history, fill and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pat   <= w_pat_nx;
      r_hist  <= w_hist_nx;
      r_fill  <= w_fill_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
`ifdef SEQDET_REG_OUT_EN
  logic r_y;
  // registered match pulse, one cycle after the hit edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_y <= 1'b0;
    else          r_y <= w_hit;
  end
  assign y = r_y;
`else
  assign y = w_hit;
`endif
endmodule

// File: tb/tb_seq_detector_fsm.sv
// tb_seq_detector_fsm: directed plus randomized check of seq_detector_fsm against a bit-queue reference model
module tb_seq_detector_fsm;
  localparam int P = 4;
  logic         clk = 0;
  logic         reset_n = 0;
  logic         in_valid = 0, x = 0, pat_load = 0, overlap = 0, cnt_clr = 0;
  logic [P-1:0] pat_in = '0;
  logic         y, armed;
  logic [7:0]   match_cnt;
  int           nchk = 0, nerr = 0;
  bit           m_armed = 0, prev_hit = 0;
  logic [P-1:0] m_pat = '0;
  int           m_cnt = 0;
  bit           q[$];

  seq_detector_fsm #(.PAT_W(P), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr), .y(y),
    .match_cnt(match_cnt), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a hit needs P-1 accepted bits since the last restart, and those bits plus x spell the pattern
  function automatic bit model_hit(bit v, bit b, bit ld);
    bit ok;
    if (!m_armed || !v || ld || q.size() < P - 1) return 0;
    ok = (b == m_pat[0]);
    for (int i = 0; i < P - 1; i++) ok &= (q[q.size() - (P - 1) + i] == m_pat[P-1-i]);
    return ok;
  endfunction

  task automatic do_reset();
    in_valid = 0; x = 0; pat_load = 0; cnt_clr = 0;
    reset_n = 0;
    #1;
    chk("rst_y", y, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_armed", armed, 0);
    m_armed = 0; m_pat = '0; m_cnt = 0; q.delete(); prev_hit = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic step(input bit v, input bit b, input bit ld, input logic [P-1:0] p, input bit ov, input bit clr);
    bit h;
    @(negedge clk);
    in_valid = v; x = b; pat_load = ld; pat_in = p; overlap = ov; cnt_clr = clr;
    #1;
    h = model_hit(v, b, ld);
`ifdef SEQDET_REG_OUT_EN
    chk("y", y, prev_hit);
`else
    chk("y", y, h);
`endif
    @(posedge clk);
    if (ld) begin
      m_pat = p; m_armed = 1; q.delete();
    end else if (m_armed && v) begin
      if (h && m_cnt < 255) m_cnt++;
      if (h && !ov) q.delete();
      else q.push_back(b);
    end
    if (clr) m_cnt = 0;
    prev_hit = h;
    #1;
    chk("cnt", match_cnt, m_cnt);
    chk("armed", armed, m_armed);
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) step(1, bits[i], 0, '0, ov, 0);
  endtask

  initial begin
    int n;
    #2;
    do_reset();
    feed(16'b1011, 4, 1);
    chk("t1_cnt", match_cnt, 0);
    chk("t1_armed", armed, 0);
    step(0, 0, 1, 4'b1011, 1, 0);
    feed(16'b1011011, 7, 1);
    chk("t2_cnt", match_cnt, 2);
    step(0, 0, 1, 4'b1011, 0, 1);
    feed(16'b1011011, 7, 0);
    chk("t3_cnt", match_cnt, 1);
    step(0, 0, 1, 4'b1011, 1, 1);
    feed(16'b101, 3, 1);
    step(1, 1, 1, 4'b1011, 1, 0);
    feed(16'b1011, 4, 1);
    chk("t4_cnt", match_cnt, 1);
    step(0, 0, 1, 4'b1111, 1, 1);
    n = 0;
    while (n < 300) begin
      if ($urandom_range(0, 3) == 0) step(0, 1, 0, '0, 1, 0);
      else begin
        step(1, 1, 0, '0, 1, 0);
        n++;
      end
    end
    chk("t5_sat", match_cnt, 255);
    step(1, 1, 0, '0, 1, 1);
    chk("t5_clr", match_cnt, 0);
    step(0, 0, 1, 4'b1011, 1, 0);
    feed(16'b10110, 5, 1);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 19) == 0,
           P'($urandom), $urandom_range(0, 1), $urandom_range(0, 29) == 0);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
